cu_sleep_requester: RTL and testbench
=====================================

Name: cu_sleep_requester

Overview:
- Per-compute-unit block, one instance per CU, clocked on the gated CU clock.
- Decides when its CU is finished and drives the CU-side sleep handshake into the GPU power/clock controller: cu_sleep_req_o and cu_delay_sleep_o.
- Debounces warp inactivity and tracks outstanding memory transactions, so the controller never asserts CU reset while responses are still in flight.

Parameters:
- NUM_WARPS, 4, number of warp-active lines monitored.
- MAX_OUTSTANDING, 15, maximum in-flight memory requests; counter width CW = $clog2(MAX_OUTSTANDING+1).
- IDLE_CYCLES, 8, consecutive all-idle cycles required before requesting sleep; legal range is 1 to 255.

Ports:
- clk_i  in  1  CU clock (gated by the controller's cu_clk_en).
- rst_i  in  1  reset, synchronous, active-high.
- cu_rst_n_i  in  1  CU reset from the controller; a low level acts as a synchronous clear, identical in effect to rst_i.
- warp_active_i  in  NUM_WARPS  per-warp active flags.
- mem_req_valid_i  in  1  CU memory request valid.
- mem_req_ready_i  in  1  memory request ready; request fires when valid & ready.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_ready_i  in  1  response ready; response fires when valid & ready.
- cu_sleep_req_o  out  1  one-cycle sleep request pulse to the controller.
- cu_delay_sleep_o  out  1  high while sleep must be deferred.
- outstanding_o  out  CW  current in-flight request count.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Clear condition: clr = rst_i | ~cu_rst_n_i.
- On clr, all of the following hold at the next edge:
  - state = RUN, idle_cnt = 0, outstanding = 0, err = 0.
  - All outputs are 0.
  - clr mid-operation aborts any state, including REQ and SLEPT.
- Outstanding counter (registered; outstanding_o is the counter value):
  - req fire only: +1.
  - rsp fire only: -1.
  - Both fire, or neither: unchanged.
  - req fire only at MAX_OUTSTANDING: hold at MAX_OUTSTANDING, set err.
  - rsp fire only at 0: hold at 0, set err.
- idle = (warp_active_i == 0). idle_cnt is 8 bits.
- FSM states:
  - RUN:
    - If !idle: idle_cnt <= 0.
    - Else if idle_cnt == IDLE_CYCLES-1: next state DRAIN (with feature) or REQ (without feature); idle_cnt <= 0.
    - Else idle_cnt++.
  - DRAIN (feature only):
    - Wait until outstanding == 0 and no req fire this cycle, then go to REQ.
    - If any warp becomes active, return to RUN with idle_cnt = 0.
  - REQ:
    - cu_sleep_req_o = 1 for exactly this one cycle.
    - Next state SLEPT unconditionally; warp activity here does not cancel the request.
  - SLEPT:
    - Terminal until clr.
    - Any warp active, or any req fire, sets err; the state is unchanged.
- cu_sleep_req_o = (state == REQ). It is a registered-state decode with no combinational input path.
- cu_delay_sleep_o (without feature): registered, equal to (next outstanding != 0).
  - It is therefore valid in the same cycle as cu_sleep_req_o.
  - It stays high until the last response fire.
- Latency (without feature): with IDLE_CYCLES = N and the first idle sample at edge k, cu_sleep_req_o is high in the cycle after edge k+N-1.
- err: sticky; cleared only by clr.

Optional Feature:
- Macro: CU_SLEEP_DRAIN_FIRST_EN.
- Defined:
  - The DRAIN state is present; the request is issued only once outstanding == 0.
  - cu_delay_sleep_o is tied to 0.
  - Latency grows by at least 1 cycle (the DRAIN pass).
- Undefined:
  - There is no DRAIN state; RUN goes directly to REQ.
  - cu_delay_sleep_o tracks outstanding as above.
  - The controller's delay input provides the deferral.

Test Plan:
- Default params, no feature; warp_active_i = 4'b0001 for 5 cycles, then 4'b0000 from edge k with no memory traffic -> cu_sleep_req_o pulses high for 1 cycle after edge k+7; cu_delay_sleep_o = 0 throughout; err_o = 0.
- Idle for 7 cycles, one cycle with warp 2 active, then idle again -> no pulse until 8 fresh consecutive idle cycles.
- Issue 3 request fires, then go idle; responses return 20 cycles later, one per cycle -> pulse occurs with cu_delay_sleep_o = 1 and outstanding_o = 3, which counts down 3, 2, 1, 0; cu_delay_sleep_o falls in the cycle after the 3rd response fire.
- Simultaneous req fire and rsp fire at outstanding = 2 -> stays 2. Rsp fire at 0 -> stays 0 and err_o = 1. 16th req fire at 15 -> holds 15 and err_o = 1.
- Reach SLEPT, then drive cu_rst_n_i = 0 for 1 cycle -> all outputs 0 and state RUN; a subsequent 8-cycle idle run produces a new pulse. Repeat the test with rst_i instead.
- With CU_SLEEP_DRAIN_FIRST_EN and 2 outstanding at the end of the debounce -> no pulse until the cycle after the 2nd rsp fire; cu_delay_sleep_o stays 0 throughout.

Source files
------------

// File: rtl/cu_sleep_requester.sv
// ---------------------------------------------------------------------------
// cu_sleep_requester
//
// Per-compute-unit sleep requester. Watches the warp-active lines and the CU
// memory handshakes, decides when the CU has finished, and drives the CU side
// of the sleep handshake into the GPU power/clock controller.
//
// Optional build macro: CU_SLEEP_DRAIN_FIRST_EN
//   undefined (default): idle debounce goes straight to REQ, and
//                        cu_delay_sleep_o tells the controller to defer
//                        while memory responses are still in flight.
//   defined            : a DRAIN state waits for zero outstanding requests
//                        before REQ, and cu_delay_sleep_o is tied low.
//
// Ports:
//   clk_i            gated CU clock
//   rst_i            synchronous active-high reset
//   cu_rst_n_i       CU reset from controller, low = synchronous clear
//   warp_active_i    per-warp active flags
//   mem_req_valid_i  memory request valid
//   mem_req_ready_i  memory request ready (fire = valid & ready)
//   mem_rsp_valid_i  memory response valid
//   mem_rsp_ready_i  memory response ready (fire = valid & ready)
//   cu_sleep_req_o   one-cycle sleep request pulse
//   cu_delay_sleep_o high while sleep must be deferred
//   outstanding_o    in-flight memory request count
//   err_o            sticky protocol error flag
// ---------------------------------------------------------------------------
module cu_sleep_requester #(
    parameter int NUM_WARPS       = 4,
    parameter int MAX_OUTSTANDING = 15,
    parameter int IDLE_CYCLES     = 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cu_rst_n_i,
    input  logic [NUM_WARPS-1:0] warp_active_i,
    input  logic                 mem_req_valid_i,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_rsp_valid_i,
    input  logic                 mem_rsp_ready_i,
    output logic                 cu_sleep_req_o,
    output logic                 cu_delay_sleep_o,
    output logic [CW-1:0]        outstanding_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REQ   = 2'd2,
        SLEPT = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_idleCnt;
    logic [CW-1:0] r_outstanding;
    logic          r_err;

    logic          w_clr;
    logic          w_idle;
    logic          w_reqFire;
    logic          w_rspFire;
    logic [CW-1:0] w_outNext;
    logic          w_errNext;

    // Either reset source clears the whole block on the next edge.
    assign w_clr     = rst_i | ~cu_rst_n_i;
    assign w_idle    = (warp_active_i == '0);
    assign w_reqFire = mem_req_valid_i & mem_req_ready_i;
    assign w_rspFire = mem_rsp_valid_i & mem_rsp_ready_i;

    // Next outstanding count and error flag. Over/underflow saturates the
    // counter and raises the sticky error; once asleep, any warp activity or
    // new request is also a protocol violation.
    always_comb begin
        w_outNext = r_outstanding;
        w_errNext = r_err;
        if (w_reqFire && !w_rspFire) begin
            if (r_outstanding == CW'(MAX_OUTSTANDING)) begin
                w_errNext = 1'b1;
            end else begin
                w_outNext = r_outstanding + 1'b1;
            end
        end else if (w_rspFire && !w_reqFire) begin
            if (r_outstanding == '0) begin
                w_errNext = 1'b1;
            end else begin
                w_outNext = r_outstanding - 1'b1;
            end
        end
        if (r_state == SLEPT && (!w_idle || w_reqFire)) begin
            w_errNext = 1'b1;
        end
    end

`ifndef CU_SLEEP_DRAIN_FIRST_EN
    logic r_delaySleep;

    // Deferral tracks the count after this edge, so it is already valid in
    // the same cycle as the sleep pulse and drops right after the last
    // response fires.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_delaySleep <= 1'b0;
        end else begin
            r_delaySleep <= (w_outNext != '0);
        end
    end

    assign cu_delay_sleep_o = r_delaySleep;
`else
    assign cu_delay_sleep_o = 1'b0;
`endif

    // Main FSM: debounce inactivity, optionally drain memory, issue a single
    // request pulse, then park in SLEPT until cleared.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state       <= RUN;
            r_idleCnt     <= 8'd0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_outNext;
            r_err         <= w_errNext;
            case (r_state)
                RUN: begin
                    if (!w_idle) begin
                        r_idleCnt <= 8'd0;
                    end else if (r_idleCnt == 8'(IDLE_CYCLES - 1)) begin
                        r_idleCnt <= 8'd0;
`ifdef CU_SLEEP_DRAIN_FIRST_EN
                        r_state   <= DRAIN;
`else
                        r_state   <= REQ;
`endif
                    end else begin
                        r_idleCnt <= r_idleCnt + 8'd1;
                    end
                end
`ifdef CU_SLEEP_DRAIN_FIRST_EN
                DRAIN: begin
                    if (!w_idle) begin
                        r_state   <= RUN;
                        r_idleCnt <= 8'd0;
                    end else if (r_outstanding == '0 && !w_reqFire) begin
                        r_state <= REQ;
                    end
                end
`endif
                REQ: begin
                    r_state <= SLEPT;
                end
                SLEPT: begin
                    r_state <= SLEPT;
                end
                default: begin
                    r_state   <= RUN;
                    r_idleCnt <= 8'd0;
                end
            endcase
        end
    end

    assign cu_sleep_req_o = (r_state == REQ);
    assign outstanding_o  = r_outstanding;
    assign err_o          = r_err;

endmodule

// File: tb/tb_cu_sleep_requester.sv
// ---------------------------------------------------------------------------
// tb_cu_sleep_requester
//
// Self-checking bench for cu_sleep_requester. Each driven cycle runs a small
// reference model whose predicted outputs are pushed to a scoreboard queue and
// popped for comparison one edge later. Directed checks on pulse timing and
// counter values follow the scenarios for the block.
// ---------------------------------------------------------------------------
module tb_cu_sleep_requester;

    localparam int NW   = 4;
    localparam int MAXO = 15;
    localparam int IDLE = 8;
    localparam int CW   = $clog2(MAXO + 1);

    localparam int S_RUN   = 0;
    localparam int S_DRAIN = 1;
    localparam int S_REQ   = 2;
    localparam int S_SLEPT = 3;

    logic          clk;
    logic          rst;
    logic          cuRstN;
    logic [NW-1:0] warpActive;
    logic          reqValid;
    logic          reqReady;
    logic          rspValid;
    logic          rspReady;
    logic          sleepReq;
    logic          delaySleep;
    logic [CW-1:0] outstanding;
    logic          err;

    typedef struct {
        logic          sleep;
        logic          delay;
        logic [CW-1:0] out;
        logic          err;
    } expT;

    expT sbQ[$];

    int testsRun;
    int testsFailed;

    int mState;
    int mIdle;
    int mOut;
    logic mErr;
    logic mDelay;

    cu_sleep_requester #(
        .NUM_WARPS(NW),
        .MAX_OUTSTANDING(MAXO),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cu_rst_n_i(cuRstN),
        .warp_active_i(warpActive),
        .mem_req_valid_i(reqValid),
        .mem_req_ready_i(reqReady),
        .mem_rsp_valid_i(rspValid),
        .mem_rsp_ready_i(rspReady),
        .cu_sleep_req_o(sleepReq),
        .cu_delay_sleep_o(delaySleep),
        .outstanding_o(outstanding),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: advance one clock edge given this cycle's inputs.
    task automatic modelStep(input logic [NW-1:0] w, input logic rqF, input logic rsF, input logic clr);
        int nOut;
        logic nErr;
        if (clr) begin
            mState = S_RUN;
            mIdle  = 0;
            mOut   = 0;
            mErr   = 1'b0;
            mDelay = 1'b0;
            return;
        end
        nOut = mOut;
        nErr = mErr;
        if (rqF && !rsF) begin
            if (mOut == MAXO) nErr = 1'b1;
            else nOut = mOut + 1;
        end else if (rsF && !rqF) begin
            if (mOut == 0) nErr = 1'b1;
            else nOut = mOut - 1;
        end
        case (mState)
            S_RUN: begin
                if (w != 0) begin
                    mIdle = 0;
                end else if (mIdle == IDLE - 1) begin
                    mIdle = 0;
`ifdef CU_SLEEP_DRAIN_FIRST_EN
                    mState = S_DRAIN;
`else
                    mState = S_REQ;
`endif
                end else begin
                    mIdle = mIdle + 1;
                end
            end
            S_DRAIN: begin
                if (w != 0) begin
                    mState = S_RUN;
                    mIdle  = 0;
                end else if (mOut == 0 && !rqF) begin
                    mState = S_REQ;
                end
            end
            S_REQ: mState = S_SLEPT;
            default: begin
                if (w != 0 || rqF) nErr = 1'b1;
            end
        endcase
`ifdef CU_SLEEP_DRAIN_FIRST_EN
        mDelay = 1'b0;
`else
        mDelay = (nOut != 0);
`endif
        mOut = nOut;
        mErr = nErr;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic applyStimulus(input logic [NW-1:0] w, input logic rqV, input logic rqR,
                                 input logic rsV, input logic rsR, input logic r, input logic crn);
        expT e;
        expT got;
        warpActive = w;
        reqValid   = rqV;
        reqReady   = rqR;
        rspValid   = rsV;
        rspReady   = rsR;
        rst        = r;
        cuRstN     = crn;
        modelStep(w, rqV & rqR, rsV & rsR, r | ~crn);
        e.sleep = (mState == S_REQ);
        e.delay = mDelay;
        e.out   = CW'(mOut);
        e.err   = mErr;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput("sleepReq", 32'(sleepReq), 32'(got.sleep));
        checkOutput("delaySleep", 32'(delaySleep), 32'(got.delay));
        checkOutput("outstanding", 32'(outstanding), 32'(got.out));
        checkOutput("err", 32'(err), 32'(got.err));
    endtask

    task automatic idleCycle();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int firstPulse;
        int pulses;
        testsRun    = 0;
        testsFailed = 0;
        mState = S_RUN;
        mIdle  = 0;
        mOut   = 0;
        mErr   = 1'b0;
        mDelay = 1'b0;

        // Reset state.
        #1;
        doReset();
        doReset();
        checkOutput("resetSleep", 32'(sleepReq), 32'd0);
        checkOutput("resetOut", 32'(outstanding), 32'd0);

        // Basic debounce: pulse after the eighth idle edge.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        firstPulse = -1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            idleCycle();
            if (sleepReq) begin
                pulses++;
                if (firstPulse < 0) firstPulse = i;
            end
            checkOutput("t1Delay", 32'(delaySleep), 32'd0);
        end
        checkOutput("t1PulseIdx", 32'(firstPulse), 32'd7);
        checkOutput("t1PulseCount", 32'(pulses), 32'd1);
        checkOutput("t1Err", 32'(err), 32'd0);

        // Activity interrupting the debounce restarts it.
        doReset();
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            idleCycle();
            if (sleepReq) pulses++;
        end
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (sleepReq) pulses++;
        checkOutput("t2EarlyPulse", 32'(pulses), 32'd0);
        firstPulse = -1;
        for (int i = 0; i < 10; i++) begin
            idleCycle();
            if (sleepReq && firstPulse < 0) firstPulse = i;
        end
        checkOutput("t2PulseIdx", 32'(firstPulse), 32'd7);

        // Outstanding requests defer sleep via the delay output.
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3OutAfterReq", 32'(outstanding), 32'd3);
        firstPulse = -1;
        for (int i = 0; i < 20; i++) begin
            idleCycle();
            if (sleepReq && firstPulse < 0) begin
                firstPulse = i;
                checkOutput("t3PulseDelay", 32'(delaySleep), 32'd1);
                checkOutput("t3PulseOut", 32'(outstanding), 32'd3);
            end
        end
        checkOutput("t3PulseIdx", 32'(firstPulse), 32'd7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput("t3CountDown", 32'(outstanding), 32'(2 - i));
            checkOutput("t3DelayFall", 32'(delaySleep), (i == 2) ? 32'd0 : 32'd1);
        end
        checkOutput("t3Err", 32'(err), 32'd0);

        // Counter boundaries.
        doReset();
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4Simul", 32'(outstanding), 32'd2);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4Drained", 32'(outstanding), 32'd0);
        checkOutput("t4NoErr", 32'(err), 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4Underflow", 32'(outstanding), 32'd0);
        checkOutput("t4UnderErr", 32'(err), 32'd1);
        doReset();
        for (int i = 0; i < 15; i++) applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4Full", 32'(outstanding), 32'd15);
        checkOutput("t4FullErr", 32'(err), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4Overflow", 32'(outstanding), 32'd15);
        checkOutput("t4OverErr", 32'(err), 32'd1);

        // Clear out of SLEPT via cu_rst_n_i, then via rst_i.
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            for (int i = 0; i < 10; i++) idleCycle();
            applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("t5SleptErr", 32'(err), 32'd1);
            if (pass == 0) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput("t5ClrErr", 32'(err), 32'd0);
            checkOutput("t5ClrSleep", 32'(sleepReq), 32'd0);
            firstPulse = -1;
            for (int i = 0; i < 10; i++) begin
                idleCycle();
                if (sleepReq && firstPulse < 0) firstPulse = i;
            end
            checkOutput("t5NewPulse", 32'(firstPulse), 32'd7);
        end

        // Clear while REQ is active aborts the pulse.
        doReset();
        for (int i = 0; i < 8; i++) idleCycle();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t6AbortReq", 32'(sleepReq), 32'd0);

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [NW-1:0] w;
            w = ($urandom_range(0, 9) < 7) ? '0 : NW'($urandom_range(1, 15));
            applyStimulus(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 49) == 0), ($urandom_range(0, 49) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
